swervolf_sseg_scan: RTL and testbench

Time-multiplexed scan controller for the Nexys A7 eight-digit, common-anode seven-segment display. It sits in the board toplevel on the core clock domain. It takes two 32-bit status words, such as the branch and taken-branch counters, and snapshots them once per scan frame. It drives the anode strobes and active-low segment lines with anti-ghosting blanking, a per-frame source selection and leading-zero suppression.

---
 rtl/swervolf_sseg_scan.sv | 158 +++++++++++++++
 tb/tb_swervolf_sseg_scan.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/swervolf_sseg_scan.sv
// Eight-digit seven-segment scan controller with per-frame snapshot,
// source select, alternate mode, leading-zero blanking and anti-ghosting.
// Ports: i_clk, i_rst (sync, active high), i_value_a/i_value_b status words,
// i_sel display mode, o_an anodes (active low), o_seg {a..g} (active low),
// o_dp decimal point (active low), o_frame snapshot pulse.
module swervolf_sseg_scan #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned ALT_FRAMES   = 250,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_value_a,
  input  logic [31:0] i_value_b,
  input  logic [1:0]  i_sel,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame
);

  localparam int unsigned CW = $clog2(DIGIT_CYCLES);
  localparam int unsigned FW =
    (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_END = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_MAX = FW'(ALT_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          src_q, src_d;
  logic [1:0]    sel_q, sel_d;
  logic [31:0]   snap_a_q, snap_a_d;
  logic [31:0]   snap_b_q, snap_b_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          frame_start;
  logic          show_b;
  logic [31:0]   word;
  logic [15:0]   half;
  logic [4:0]    sh;
  logic [3:0]    nib;
  logic          lead;
  logic          suppress;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign frame_start = (cnt_q == '0) && (dig_q == 3'd0);

  always_comb begin
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    dig_d    = (cnt_q == CNT_MAX) ? dig_q + 3'd1 : dig_q;
    sel_d    = sel_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    fcnt_d   = fcnt_q;
    src_d    = src_q;
    if (frame_start) begin
      sel_d    = i_sel;
      snap_a_d = i_value_a;
      snap_b_d = i_value_b;
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d = '0;
        src_d  = ~src_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Split mode treats each 16-bit half as its own number, so the
  // zero test only looks upward within the half that owns the digit.
  always_comb begin
    show_b = (sel_q == 2'd2) || ((sel_q == 2'd3) && src_q);
    word   = show_b ? snap_b_q : snap_a_q;
    half   = dig_q[2] ? snap_b_q[15:0] : snap_a_q[15:0];
    sh     = {dig_q, 2'b00};
    if (sel_q == 2'd0) begin
      nib  = half[sh[3:0] +: 4];
      lead = (dig_q[1:0] != 2'd0) &&
             ((half >> sh[3:0]) == 16'h0);
    end else begin
      nib  = word[sh +: 4];
      lead = (dig_q != 3'd0) && ((word >> sh) == 32'h0);
    end
    suppress = LZ_BLANK && lead;
    frame_d  = frame_start;
    if (cnt_q < BLK_END || suppress) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(8'd1 << dig_q);
      seg_d = hex7(nib);
      dp_d  = ~((dig_q == 3'd0) && show_b);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      dig_q    <= 3'd0;
      fcnt_q   <= '0;
      src_q    <= 1'b0;
      sel_q    <= 2'd0;
      snap_a_q <= 32'h0;
      snap_b_q <= 32'h0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      fcnt_q   <= fcnt_d;
      src_q    <= src_d;
      sel_q    <= sel_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_swervolf_sseg_scan.sv
// Bench for swervolf_sseg_scan: reference model of the scan plus
// directed scenarios with literal expectations.
module tb_swervolf_sseg_scan;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int AF = 2;
  localparam int FP = DC * 8;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       care;
  } out_t;

  localparam out_t RST_OUT = '{8'hFF, 7'h7F, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] va = 32'h0;
  logic [31:0] vb = 32'h0;
  logic [1:0]  sel = 2'd0;

  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fr0, fr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  swervolf_sseg_scan #(
    .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
    .ALT_FRAMES(AF), .LZ_BLANK(1'b0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_value_a(va), .i_value_b(vb), .i_sel(sel),
    .o_an(an0), .o_seg(seg0), .o_dp(dp0), .o_frame(fr0)
  );

  swervolf_sseg_scan #(
    .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
    .ALT_FRAMES(AF), .LZ_BLANK(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_value_a(va), .i_value_b(vb), .i_sel(sel),
    .o_an(an1), .o_seg(seg1), .o_dp(dp1), .o_frame(fr1)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tbl[n];
  endfunction

  // Expected outputs for the scan position t cycles after a frame-0 start.
  function automatic out_t model_out(
    input bit lz, input int tt,
    input logic [31:0] a, input logic [31:0] b,
    input logic [1:0] s, input logic src);
    out_t o;
    int cnt, dig, top, base;
    bit showb, blank;
    logic [31:0] w;
    logic [3:0] nb [8];
    cnt = tt % DC;
    dig = (tt / DC) % 8;
    showb = (s == 2'd2) || (s == 2'd3 && src);
    if (s == 2'd0) w = {b[15:0], a[15:0]};
    else w = showb ? b : a;
    for (int k = 0; k < 8; k++) nb[k] = w[4*k +: 4];
    base = (s == 2'd0) ? (dig / 4) * 4 : 0;
    top = (s == 2'd0) ? base + 3 : 7;
    blank = 1'b0;
    if (lz && dig != base) begin
      blank = 1'b1;
      for (int j = dig; j <= top; j++)
        if (nb[j] != 4'h0) blank = 1'b0;
    end
    if (cnt < BC) o = RST_OUT;
    else if (blank) o = '{8'hFF, 7'h7F, 1'b1, 1'b0};
    else o = '{~(8'd1 << dig), seg_of(nb[dig]),
               !(dig == 0 && showb), 1'b1};
    return o;
  endfunction

  int          t;
  int          exp_t;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_sel;
  logic        m_src;
  out_t        e0, e1;
  logic        e_fr;
  bit          started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      t <= 0; exp_t <= -1;
      m_a <= 32'h0; m_b <= 32'h0; m_sel <= 2'd0; m_src <= 1'b0;
      e0 <= RST_OUT; e1 <= RST_OUT; e_fr <= 1'b0;
    end else begin
      e0 <= model_out(1'b0, t, m_a, m_b, m_sel, m_src);
      e1 <= model_out(1'b1, t, m_a, m_b, m_sel, m_src);
      e_fr <= (t % FP == 0);
      exp_t <= t;
      if (t % FP == 0) begin
        m_a <= va; m_b <= vb; m_sel <= sel;
        m_src <= 1'(((t / FP + 1) / AF) % 2);
      end
      t <= t + 1;
    end
  end

  task automatic cmp(input string nm, input out_t e, input logic ef,
                     input logic [7:0] an, input logic [6:0] seg,
                     input logic dp, input logic fr);
    checks++;
    if (an !== e.an) begin
      errors++;
      $display("FAIL %s an t=%0d: got %h want %h", nm, exp_t, an, e.an);
    end
    checks++;
    if (fr !== ef) begin
      errors++;
      $display("FAIL %s frame t=%0d: got %b want %b", nm, exp_t, fr, ef);
    end
    if (e.care) begin
      checks++;
      if (seg !== e.seg || dp !== e.dp) begin
        errors++;
        $display("FAIL %s seg/dp t=%0d: got %b/%b want %b/%b",
                 nm, exp_t, seg, dp, e.seg, e.dp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("model0", e0, e_fr, an0, seg0, dp0, fr0);
      cmp("model1", e1, e_fr, an1, seg1, dp1, fr1);
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_t(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (exp_t == target) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_t: timeout got %0d want %0d", exp_t, target);
    end
  endtask

  initial begin
    sel = 2'd1; va = 32'h76543210; vb = 32'h0;
    @(negedge clk);
    chk("rst_an", an0, 8'hFF);
    chk("rst_seg", {1'b0, seg1}, 8'h7F);
    chk("rst_frame", {7'h0, fr1}, 8'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: mode 1, no blanking
    wait_t(0);
    chk("s1_frame", {7'h0, fr0}, 8'h1);
    wait_t(1);
    chk("s1_blank", an0, 8'hFF);
    wait_t(2);
    chk("s1_d0_an", an0, 8'hFE);
    chk("s1_d0_seg", {1'b0, seg0}, 8'h01);
    wait_t(58);
    chk("s1_d7_an", an0, 8'h7F);
    chk("s1_d7_seg", {1'b0, seg0}, {1'b0, 7'b0001111});
    va = 32'h000000A0;

    // 2: leading-zero blanking in 32-bit mode
    wait_t(74);
    chk("s2_d1_an", an1, 8'hFD);
    chk("s2_d1_seg", {1'b0, seg1}, {1'b0, 7'b0001000});
    wait_t(83);
    chk("s2_d2_an", an1, 8'hFF);
    va = 32'h0;
    wait_t(130);
    chk("s2_z0_an", an1, 8'hFE);
    chk("s2_z0_seg", {1'b0, seg1}, 8'h01);
    wait_t(138);
    chk("s2_z1_an", an1, 8'hFF);
    sel = 2'd0; va = 32'h12340005; vb = 32'h000000F0;

    // 3: split mode
    wait_t(194);
    chk("s3_d0_seg", {1'b0, seg1}, {1'b0, 7'b0100100});
    wait_t(202);
    chk("s3_d1_an", an1, 8'hFF);
    wait_t(226);
    chk("s3_d4_an", an1, 8'hEF);
    chk("s3_d4_seg", {1'b0, seg1}, 8'h01);
    wait_t(234);
    chk("s3_d5_seg", {1'b0, seg1}, {1'b0, 7'b0111000});
    wait_t(242);
    chk("s3_d6_an", an1, 8'hFF);
    wait_t(250);
    chk("s3_nolz_d7", an0, 8'h7F);
    sel = 2'd3; va = 32'h1; vb = 32'h2;

    // 4: alternate mode, frames 4..7 show A,B,B,A
    wait_t(258);
    chk("s4_f4_seg", {1'b0, seg1}, {1'b0, 7'b1001111});
    chk("s4_f4_dp", {7'h0, dp1}, 8'h1);
    wait_t(322);
    chk("s4_f5_seg", {1'b0, seg1}, {1'b0, 7'b0010010});
    chk("s4_f5_dp", {7'h0, dp1}, 8'h0);
    wait_t(386);
    chk("s4_f6_dp", {7'h0, dp1}, 8'h0);
    wait_t(450);
    chk("s4_f7_seg", {1'b0, seg1}, {1'b0, 7'b1001111});
    chk("s4_f7_dp", {7'h0, dp1}, 8'h1);

    // 5: mid-frame change ignored until next frame
    wait_t(536);
    sel = 2'd2; va = 32'h89ABCDEF;
    wait_t(554);
    chk("s5_old_an", an0, 8'hDF);
    chk("s5_old_seg", {1'b0, seg0}, 8'h01);
    chk("s5_old_lz", an1, 8'hFF);
    wait_t(578);
    chk("s5_new_seg", {1'b0, seg1}, {1'b0, 7'b0010010});
    chk("s5_new_dp", {7'h0, dp1}, 8'h0);

    // 6: reset in the drive phase of digit 5
    wait_t(619);
    chk("s6_pre_an", an0, 8'hDF);
    rst = 1'b1; sel = 2'd1; va = 32'h00000C00;
    @(negedge clk);
    chk("s6_an", an0, 8'hFF);
    chk("s6_seg", {1'b0, seg0}, 8'h7F);
    chk("s6_dp", {7'h0, dp0}, 8'h1);
    rst = 1'b0;
    wait_t(0);
    chk("s6_frame", {7'h0, fr1}, 8'h1);
    wait_t(2);
    chk("s6_d0_an", an1, 8'hFE);
    wait_t(18);
    chk("s6_d2_an", an1, 8'hFB);
    chk("s6_d2_seg", {1'b0, seg1}, {1'b0, 7'b0110001});
    wait_t(70);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
